// File: rtl/data_cache.sv
// data_cache: direct-mapped, one-word-per-line, write-through /
// no-write-allocate data cache sitting between a CPU memory stage and a
// backing memory. Load hits complete combinationally in the request cycle.
// Misses fill the line from backing memory, and the request then hits on the
// following cycle. Stores are always written through to backing memory.
module data_cache #(
  parameter int WIDTH = 32,
  parameter int SETS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_write_m,
  input  logic [WIDTH-1:0] ex_out_m,
  input  logic [WIDTH-1:0] write_data_m,
  input  logic [2:0]       funct3_m,
  output logic             mem_ready,
  output logic [WIDTH-1:0] read_data_m,
  output logic             bm_req,
  output logic             bm_we,
  output logic [WIDTH-1:0] bm_addr,
  output logic [WIDTH-1:0] bm_wdata,
  output logic [3:0]       bm_wstrb,
  input  logic             bm_ack,
  input  logic [WIDTH-1:0] bm_rdata,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
);

  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = WIDTH - 2 - IDXW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_r, state_s;

  // Request captured on acceptance so the backing access stays stable
  // even if the CPU side changes during FILL or WRITE.
  logic [WIDTH-1:0] addr_r;
  logic [WIDTH-1:0] wdata_r;
  logic [2:0]       funct3_r;

  logic [SETS-1:0]  valid_r;
  logic [TAGW-1:0]  tag_r  [SETS];
  logic [WIDTH-1:0] data_r [SETS];

  logic [31:0]      hit_count_r;
  logic [31:0]      miss_count_r;

  logic [WIDTH-1:0] look_addr_s;
  logic [IDXW-1:0]  idx_s;
  logic [TAGW-1:0]  tag_s;
  logic             line_hit_s;
  logic             load_hit_s;
  logic             load_miss_s;
  logic             accept_s;
  logic [WIDTH-1:0] merge_s;

  // Sign/zero-extended extraction of the addressed byte or halfword.
  function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] word,
                                                    input logic [1:0] off,
                                                    input logic [2:0] f3);
    logic [7:0]       b;
    logic [15:0]      h;
    logic [WIDTH-1:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{(WIDTH-8){b[7]}}, b};
      3'b001:  r = {{(WIDTH-16){h[15]}}, h};
      3'b100:  r = {{(WIDTH-8){1'b0}}, b};
      3'b101:  r = {{(WIDTH-16){1'b0}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Store data replicated onto every lane it could occupy.
  function automatic logic [WIDTH-1:0] store_lanes(input logic [WIDTH-1:0] data,
                                                   input logic [2:0] f3);
    logic [WIDTH-1:0] r;
    case (f3)
      3'b000:  r = {4{data[7:0]}};
      3'b001:  r = {2{data[15:0]}};
      default: r = data;
    endcase
    return r;
  endfunction

  // Byte-lane strobes for a store of the given size at the given offset.
  function automatic logic [3:0] store_strobe(input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [3:0] r;
    case (f3)
      3'b000:  r = 4'b0001 << off;
      3'b001:  r = off[1] ? 4'b1100 : 4'b0011;
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Lookup address: the live CPU address in IDLE, the captured one otherwise.
  always_comb begin
    look_addr_s = addr_r;
    if (state_r == IDLE) begin
      look_addr_s = ex_out_m;
    end else begin
      look_addr_s = addr_r;
    end
    idx_s       = look_addr_s[IDXW+1:2];
    tag_s       = look_addr_s[WIDTH-1:IDXW+2];
    line_hit_s  = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    accept_s    = (state_r == IDLE) && mem_valid;
    load_hit_s  = accept_s && !mem_write_m && line_hit_s;
    load_miss_s = accept_s && !mem_write_m && !line_hit_s;
  end

  // CPU-side and backing-side outputs decoded from state and captured request.
  always_comb begin
    mem_ready   = load_hit_s || (state_r == DONE);
    read_data_m = {WIDTH{1'b0}};
    if (load_hit_s) begin
      read_data_m = load_extract(data_r[idx_s], ex_out_m[1:0], funct3_m);
    end else begin
      read_data_m = {WIDTH{1'b0}};
    end
    bm_req   = (state_r == FILL) || (state_r == WRITE);
    bm_we    = (state_r == WRITE);
    bm_addr  = {addr_r[WIDTH-1:2], 2'b00};
    bm_wdata = {WIDTH{1'b0}};
    bm_wstrb = 4'b0000;
    if (state_r == WRITE) begin
      bm_wdata = store_lanes(wdata_r, funct3_r);
      bm_wstrb = store_strobe(addr_r[1:0], funct3_r);
    end else begin
      bm_wdata = {WIDTH{1'b0}};
      bm_wstrb = 4'b0000;
    end
  end

  // Cached word with the strobed store bytes merged in.
  always_comb begin
    merge_s = data_r[idx_s];
    for (int b = 0; b < 4; b++) begin
      if (bm_wstrb[b]) begin
        merge_s[8*b +: 8] = bm_wdata[8*b +: 8];
      end else begin
        merge_s[8*b +: 8] = data_r[idx_s][8*b +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && mem_write_m) begin
          state_s = WRITE;
        end else if (load_miss_s) begin
          state_s = FILL;
        end else begin
          state_s = IDLE;
        end
      end
      FILL: begin
        if (bm_ack) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      WRITE: begin
        if (bm_ack) begin
          state_s = DONE;
        end else begin
          state_s = WRITE;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, captured request and valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= {WIDTH{1'b0}};
      wdata_r  <= {WIDTH{1'b0}};
      funct3_r <= 3'b000;
      valid_r  <= {SETS{1'b0}};
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        addr_r   <= ex_out_m;
        wdata_r  <= write_data_m;
        funct3_r <= funct3_m;
      end
      if ((state_r == FILL) && bm_ack) begin
        valid_r[idx_s] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: filled on a completed read, merged on a store hit.
  always_ff @(posedge clk) begin
    if ((state_r == FILL) && bm_ack) begin
      data_r[idx_s] <= bm_rdata;
      tag_r[idx_s]  <= tag_s;
    end else if ((state_r == WRITE) && bm_ack && line_hit_s) begin
      data_r[idx_s] <= merge_s;
    end
  end

  // Load hit and miss counters, wrapping modulo 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else begin
      if (load_hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (load_miss_s) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache (default WIDTH=32, SETS=64).
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_write_m;
  logic [31:0] ex_out_m;
  logic [31:0] write_data_m;
  logic [2:0]  funct3_m;
  logic        mem_ready;
  logic [31:0] read_data_m;
  logic        bm_req;
  logic        bm_we;
  logic [31:0] bm_addr;
  logic [31:0] bm_wdata;
  logic [3:0]  bm_wstrb;
  logic        bm_ack;
  logic [31:0] bm_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks   = 0;
  int failures = 0;

  // Results of the last transaction.
  int          r_cyc;
  int          r_bmreq;
  logic [31:0] r_data;
  logic [31:0] r_bm_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic        r_we;

  data_cache dut (
    .clk          (clk),
    .rst          (rst),
    .mem_valid    (mem_valid),
    .mem_write_m  (mem_write_m),
    .ex_out_m     (ex_out_m),
    .write_data_m (write_data_m),
    .funct3_m     (funct3_m),
    .mem_ready    (mem_ready),
    .read_data_m  (read_data_m),
    .bm_req       (bm_req),
    .bm_we        (bm_we),
    .bm_addr      (bm_addr),
    .bm_wdata     (bm_wdata),
    .bm_wstrb     (bm_wstrb),
    .bm_ack       (bm_ack),
    .bm_rdata     (bm_rdata),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU request. Cycle 1 is the request cycle; backing memory acks on
  // its ack_at-th bm_req cycle. r_cyc is the cycle mem_ready was seen (0 = timeout).
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int ack_at, input logic [31:0] rd);
    mem_valid = 1'b1; mem_write_m = we; ex_out_m = addr; funct3_m = f3; write_data_m = wd;
    r_cyc = 0; r_bmreq = 0; r_data = 32'h0; r_bm_addr = 32'h0;
    r_wdata = 32'h0; r_strb = 4'h0; r_we = 1'b0;
    for (int c = 1; c <= 40 && r_cyc == 0; c++) begin
      @(negedge clk);
      if (mem_ready) begin
        r_cyc  = c;
        r_data = read_data_m;
      end else if (bm_req) begin
        r_bmreq++;
        r_bm_addr = bm_addr; r_wdata = bm_wdata; r_strb = bm_wstrb; r_we = bm_we;
        if (r_bmreq == ack_at) begin
          bm_ack = 1'b1; bm_rdata = rd;
        end
      end
      @(posedge clk); #1;
      bm_ack = 1'b0; bm_rdata = 32'h0;
    end
    mem_valid = 1'b0; mem_write_m = 1'b0;
  endtask

  // After a request completes with mem_valid low: no second ready, no new access.
  task automatic chk_quiet(input string tag);
    @(negedge clk);
    chk({tag, "_ready_low"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_bmreq_low"}, {31'd0, bm_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; mem_valid = 1'b0; mem_write_m = 1'b0; ex_out_m = 32'h0;
    write_data_m = 32'h0; funct3_m = 3'b010; bm_ack = 1'b0; bm_rdata = 32'h0;
    #2;
    chk("rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("rst_bmreq", {31'd0, bm_req}, 32'd0);
    chk("rst_bmwe", {31'd0, bm_we}, 32'd0);
    chk("rst_rdata", read_data_m, 32'h0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_misses", miss_count, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_quiet("idle");

    // Cold LW 0x100, ack on 3rd fill cycle
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 3, 32'hDEADBEEF);
    chk("cold_ready_cycle", r_cyc, 32'd5);
    chk("cold_rdata", r_data, 32'hDEADBEEF);
    chk("cold_bm_addr", r_bm_addr, 32'h100);
    chk("cold_misses", miss_count, 32'd1);
    chk("cold_hits", hit_count, 32'd1);
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 1, 32'h0);
    chk("rep_ready_cycle", r_cyc, 32'd1);
    chk("rep_no_bmreq", r_bmreq, 32'd0);
    chk("rep_hits", hit_count, 32'd2);

    // SW 0x100 on a hit makes the line 0x80FF7F01
    do_req(1'b1, 32'h100, 3'b010, 32'h80FF7F01, 1, 32'h0);
    chk("sw_ready_cycle", r_cyc, 32'd3);
    chk("sw_strb", {28'd0, r_strb}, 32'hF);
    chk("sw_wdata", r_wdata, 32'h80FF7F01);
    chk_quiet("sw_after");

    do_req(1'b0, 32'h103, 3'b000, 32'h0, 1, 32'h0);
    chk("lb_103", r_data, 32'hFFFFFF80);
    do_req(1'b0, 32'h103, 3'b100, 32'h0, 1, 32'h0);
    chk("lbu_103", r_data, 32'h00000080);
    do_req(1'b0, 32'h102, 3'b001, 32'h0, 1, 32'h0);
    chk("lh_102", r_data, 32'hFFFF80FF);
    do_req(1'b0, 32'h100, 3'b101, 32'h0, 1, 32'h0);
    chk("lhu_100", r_data, 32'h00007F01);
    do_req(1'b0, 32'h103, 3'b001, 32'h0, 1, 32'h0);
    chk("lh_103_odd", r_data, 32'hFFFF80FF);
    chk("ext_hits", hit_count, 32'd7);

    // SB 0x101 data 0xAB, ack on 2nd write cycle
    do_req(1'b1, 32'h101, 3'b000, 32'h000000AB, 2, 32'h0);
    chk("sb_strb", {28'd0, r_strb}, 32'h2);
    chk("sb_wdata", r_wdata, 32'hABABABAB);
    chk("sb_we", {31'd0, r_we}, 32'd1);
    chk("sb_bm_addr", r_bm_addr, 32'h100);
    chk("sb_bmreq_cycles", r_bmreq, 32'd2);
    chk("sb_ready_cycle", r_cyc, 32'd4);
    chk_quiet("sb_after");
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 1, 32'h0);
    chk("sb_lw_cycle", r_cyc, 32'd1);
    chk("sb_lw_data", r_data, 32'h80FFAB01);

    // SH 0x102 data 0x1234
    do_req(1'b1, 32'h102, 3'b001, 32'hFFFF1234, 1, 32'h0);
    chk("sh_strb", {28'd0, r_strb}, 32'hC);
    chk("sh_wdata", r_wdata, 32'h12341234);
    chk_quiet("sh_after");
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 1, 32'h0);
    chk("sh_lw_data", r_data, 32'h1234AB01);
    chk("sh_hits", hit_count, 32'd9);

    // SW 0x200 misses: written through, not allocated
    do_req(1'b1, 32'h200, 3'b010, 32'h01020304, 1, 32'h0);
    chk("swm_we", {31'd0, r_we}, 32'd1);
    chk("swm_bm_addr", r_bm_addr, 32'h200);
    chk("swm_strb", {28'd0, r_strb}, 32'hF);
    chk("swm_ready_cycle", r_cyc, 32'd3);
    chk_quiet("swm_after");
    do_req(1'b0, 32'h200, 3'b010, 32'h0, 1, 32'h55AA55AA);
    chk("lwm_ready_cycle", r_cyc, 32'd3);
    chk("lwm_data", r_data, 32'h55AA55AA);
    chk("lwm_misses", miss_count, 32'd2);

    // Conflict: 0x100 and 0x200 share index 0
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 2, 32'h11112222);
    chk("cf1_ready_cycle", r_cyc, 32'd4);
    chk("cf1_data", r_data, 32'h11112222);
    do_req(1'b0, 32'h200, 3'b010, 32'h0, 1, 32'h33334444);
    chk("cf2_ready_cycle", r_cyc, 32'd3);
    chk("cf2_data", r_data, 32'h33334444);
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 1, 32'h55556666);
    chk("cf3_ready_cycle", r_cyc, 32'd3);
    chk("cf3_data", r_data, 32'h55556666);
    chk("cf_misses", miss_count, 32'd5);
    chk("cf_hits", hit_count, 32'd13);

    // Reset pulse in the middle of a fill
    mem_valid = 1'b1; mem_write_m = 1'b0; ex_out_m = 32'h300; funct3_m = 3'b010;
    @(negedge clk);
    chk("mf_miss_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mf_fill_bmreq", {31'd0, bm_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mf_rst_bmreq", {31'd0, bm_req}, 32'd0);
    chk("mf_rst_ready", {31'd0, mem_ready}, 32'd0);
    chk("mf_rst_misses", miss_count, 32'd0);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_quiet("mf_release");
    do_req(1'b0, 32'h100, 3'b010, 32'h0, 1, 32'hCAFEF00D);
    chk("mf_lw_ready_cycle", r_cyc, 32'd3);
    chk("mf_lw_data", r_data, 32'hCAFEF00D);
    chk("mf_lw_misses", miss_count, 32'd1);
    chk("mf_lw_hits", hit_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
